// File: rtl/control_pipeline_if.sv
// Fetch/bus control bundle between the memory front end and the instruction pipeline.
interface control_pipeline_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 16
);

  logic [WIDTH-1:0]        bus_in;
  logic                    bus_request;
  logic                    fetch_suppress;
  logic                    pcra_flip;
  logic                    stall;
  logic                    pcra0_inc;
  logic                    pcra1_inc;
  logic                    pcra_sel;
  logic [STAGES*WIDTH-1:0] instr_out;
  logic [STAGES-1:0]       valid_out;
  logic [CNT_W-1:0]        retired_count;

  // Front end: drives fetch controls, observes pipeline state
  modport master (
    output bus_in, bus_request, fetch_suppress, pcra_flip, stall,
    input  pcra0_inc, pcra1_inc, pcra_sel, instr_out, valid_out, retired_count
  );

  // Pipeline: consumes fetch controls, publishes pipeline state
  modport slave (
    input  bus_in, bus_request, fetch_suppress, pcra_flip, stall,
    output pcra0_inc, pcra1_inc, pcra_sel, instr_out, valid_out, retired_count
  );

endinterface

// File: rtl/control_pipeline.sv
// Instruction fetch pipeline with dual program-counter select, bubble insertion
// and a retired-instruction counter.
module control_pipeline #(
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      STAGES = 3,
  parameter logic [WIDTH-1:0] NOP    = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  control_pipeline_if.slave bus
);

  localparam int unsigned LAST = STAGES - 1;

  // Per-edge action after priority resolution
  typedef enum logic [2:0] {
    OP_RESET,
    OP_STALL,
    OP_FLIP,
    OP_BUBBLE,
    OP_FETCH
  } op_e;

  op_e              op;
  logic             fetch_en;
  logic             retire;

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic             sel_q;
  logic             sel_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Resolve reset > stall > flip > bus_request > fetch_suppress > normal
  always_comb begin
    op = OP_FETCH;
    if (!reset_n) begin
      op = OP_RESET;
    end else if (bus.stall) begin
      op = OP_STALL;
    end else if (bus.pcra_flip) begin
      op = OP_FLIP;
    end else if (bus.bus_request || bus.fetch_suppress) begin
      op = OP_BUBBLE;
    end
  end

  // PC increments whenever the bus is ours, including suppressed operand bytes
  assign fetch_en      = reset_n & ~bus.stall & ~bus.pcra_flip & ~bus.bus_request;
  assign bus.pcra0_inc = fetch_en & ~sel_q;
  assign bus.pcra1_inc = fetch_en & sel_q;

  // Last stage leaves the pipe on every non-stall edge, flip included
  assign retire = valid_q[LAST] & ((op == OP_FLIP) | (op == OP_BUBBLE) | (op == OP_FETCH));

  // Next-state for stages, valid bits, PC select and retire counter
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    case (op)
      OP_RESET: begin
        for (int k = 0; k < STAGES; k++) begin
          stage_d[k] = NOP;
        end
        valid_d = '0;
        sel_d   = 1'b0;
        cnt_d   = '0;
      end
      OP_STALL: begin
        // hold everything
      end
      OP_FLIP: begin
        for (int k = 0; k < STAGES; k++) begin
          stage_d[k] = NOP;
        end
        valid_d = '0;
        sel_d   = ~sel_q;
      end
      OP_BUBBLE, OP_FETCH: begin
        for (int k = 1; k < STAGES; k++) begin
          stage_d[k] = stage_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
        stage_d[0] = (op == OP_FETCH) ? bus.bus_in : NOP;
        valid_d[0] = (op == OP_FETCH);
      end
      default: begin
        // unreachable encodings hold state
      end
    endcase

    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline state registers with synchronous active-low reset folded into op
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
    valid_q <= valid_d;
    sel_q   <= sel_d;
    cnt_q   <= cnt_d;
  end

  // Publish packed stage view; stage k at bits [k*WIDTH +: WIDTH]
  for (genvar k = 0; k < STAGES; k++) begin : g_pack
    assign bus.instr_out[k*WIDTH +: WIDTH] = stage_q[k];
  end

  assign bus.valid_out     = valid_q;
  assign bus.pcra_sel      = sel_q;
  assign bus.retired_count = cnt_q;

endmodule

// File: doc/control_pipeline.md
CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 8: instruction byte width.
REQ-002 SHALL have parameter STAGES, default 3, legal range 2..4: number of instruction pipeline registers.
REQ-003 SHALL have parameter NOP, default {WIDTH{1'b0}}: the instruction value used for bubbles.
REQ-004 SHALL have parameter CNT_W, default 16: retired-instruction counter width.
REQ-005 clk  input  1  sole clock; every register updates on its rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 bus_in  input  WIDTH  byte fetched from memory at the active program counter.
REQ-008 bus_request  input  1  last stage owns the bus this cycle, so no fetch takes place.
REQ-009 fetch_suppress  input  1  the byte on bus_in is an operand consumed elsewhere, not an opcode.
REQ-010 pcra_flip  input  1  swap the active program-counter register and flush the pipeline.
REQ-011 stall  input  1  freeze the whole pipeline (memory wait state).
REQ-012 pcra0_inc, pcra1_inc  output  1 each  increment strobe for the active program counter.
REQ-013 pcra_sel  output  1  active program counter: 0 = pcra0, 1 = pcra1.
REQ-014 instr_out  output  STAGES*WIDTH  stage registers packed; stage k occupies bits [k*WIDTH +: WIDTH].
REQ-015 valid_out  output  STAGES  bit k = 1 when stage k holds a real instruction rather than a bubble.
REQ-016 retired_count  output  CNT_W  count of valid instructions that have left the last stage.

Function
REQ-017 fetch_en SHALL be reset_n & ~stall & ~pcra_flip & ~bus_request (combinational).
REQ-018 pcra0_inc SHALL be fetch_en & ~pcra_sel, and pcra1_inc SHALL be fetch_en & pcra_sel (combinational, no latency).
REQ-019 The program counter SHALL still increment when fetch_suppress=1, because the operand byte is consumed.
REQ-020 Per-edge priority SHALL be: reset > stall > pcra_flip > bus_request > fetch_suppress > normal.
REQ-021 Stall: all stages, valid bits, pcra_sel and retired_count SHALL hold their values.
REQ-022 Flip: pcra_sel SHALL toggle, and every stage SHALL load NOP with valid 0.
REQ-023 Bus request: stages k>=1 SHALL shift (stage[k] <= stage[k-1]), and stage0 SHALL load NOP with valid 0.
REQ-024 Fetch suppress: stages SHALL shift, and stage0 SHALL load NOP with valid 0.
REQ-025 Normal: stages SHALL shift, and stage0 SHALL load bus_in with valid 1.
REQ-026 bus_request and fetch_suppress asserted together SHALL be handled as bus_request.
REQ-027 Retire: on any non-stall, non-flip edge where valid_out[STAGES-1]=1, retired_count SHALL increment by 1.
REQ-028 On a flip edge, the last-stage instruction SHALL count as retired when valid, because the flip is issued by that instruction.
REQ-029 retired_count SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-030 Latency: a byte fetched at edge n SHALL appear in stage k after edge n+k, given no stall, flip or bus request.
REQ-031 Stage outputs SHALL be registered; no combinational path SHALL exist from bus_in to instr_out.

Reset
REQ-032 While reset_n=0 at a rising edge, every stage SHALL load NOP, valid_out SHALL be 0, pcra_sel SHALL be 0 and retired_count SHALL be 0.
REQ-033 pcra0_inc and pcra1_inc SHALL be 0 combinationally while reset_n=0.
REQ-034 Reset asserted mid-stall or mid-flip SHALL override both; the first edge after release SHALL behave as normal.

Verification (WIDTH=8, STAGES=3, NOP=00)
REQ-035 Reset then feed bus_in 11,22,33,44 on consecutive cycles:
- stage2 shows 11 after the 3rd edge, then 22, 33;
- pcra0_inc=1 every cycle;
- retired_count=1 after the 4th edge.
REQ-036 Feed 11, then 22 with fetch_suppress=1, then 33:
- stage0 sequence is 11, 00(v=0), 33;
- pcra0_inc=1 on all three cycles;
- retired_count rises by 2, not 3.
REQ-037 With stages 11,22,33, assert stall for 2 cycles:
- instr_out, valid_out and retired_count are unchanged;
- pcra0_inc=0 throughout.
REQ-038 With stages 11,22,33 (all valid), assert pcra_flip for 1 cycle:
- pcra_sel becomes 1 and all stages become 00 with v=0;
- retired_count increments by 1;
- on the next fetch pcra1_inc=1 and pcra0_inc=0.
REQ-039 Assert bus_request and fetch_suppress together:
- stage0 becomes 00 with v=0;
- pcra0_inc=pcra1_inc=0.
Preload retired_count to FFFF with CNT_W=16, then retire one instruction: retired_count becomes 0000.
REQ-040 Assert reset_n=0 for one edge during a stall with stages valid: all outputs return to their reset values.
